// File: rtl/sisc_run_ctrl.sv
// Run controller for the SISC core: holds the core in reset, releases it, watches
// fetches for the halt opcode, enforces a watchdog and reports run statistics.
module sisc_run_ctrl #(
    parameter int         RST_CYCLES = 2,
    parameter int         TIMEOUT    = 1000,
    parameter logic [3:0] HALT_OP    = 4'hF,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             ir_load,
    output logic             core_rst_f,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_TOUT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [HW-1:0]    r_hold;
    logic [HW-1:0]    w_hold_next;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] w_cycle_next;
    logic [CNT_W-1:0] r_instr;
    logic [CNT_W-1:0] w_instr_next;
    logic             r_core_rst_f;
    logic             r_running;
    logic             r_done;
    logic             r_timeout;
    logic             w_halt;
    logic             w_wdog;
    logic             w_unused_ir;

    assign w_unused_ir = ^ir[27:0];
    assign w_halt      = ir_load && (ir[31:28] == HALT_OP);
    assign w_wdog      = (TIMEOUT != 0) && (r_cycle == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_cycle_next = r_cycle;
        w_instr_next = r_instr;
        case (r_state)
            S_HOLD: begin
                if (r_hold == HW'(RST_CYCLES - 1)) begin
                    w_state_next = S_RUN;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold + 1'b1;
                end
            end
            S_RUN: begin
                w_cycle_next = r_cycle + 1'b1;
                if (ir_load) begin
                    w_instr_next = r_instr + 1'b1;
                end
                // Halt takes priority over a watchdog expiry on the same edge.
                if (w_halt) begin
                    w_state_next = S_DONE;
                end else if (w_wdog) begin
                    w_state_next = S_TOUT;
                end
            end
            S_DONE, S_TOUT: begin
                if (start) begin
                    w_state_next = S_HOLD;
                    w_hold_next  = '0;
                    w_cycle_next = '0;
                    w_instr_next = '0;
                end
            end
            default: begin
                w_state_next = S_HOLD;
                w_hold_next  = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they move with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_HOLD;
            r_hold       <= '0;
            r_cycle      <= '0;
            r_instr      <= '0;
            r_core_rst_f <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hold       <= w_hold_next;
            r_cycle      <= w_cycle_next;
            r_instr      <= w_instr_next;
            r_core_rst_f <= (w_state_next == S_RUN);
            r_running    <= (w_state_next == S_RUN);
            r_done       <= (w_state_next == S_DONE);
            r_timeout    <= (w_state_next == S_TOUT);
        end
    end

    assign core_rst_f  = r_core_rst_f;
    assign running     = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle;
    assign instr_count = r_instr;

endmodule

// File: tb/tb_sisc_run_ctrl.sv
// Directed bench for sisc_run_ctrl: power-up hold, halt, watchdog, tie-break,
// restart, ignored start/fetches and asynchronous reset mid-run.
module tb_sisc_run_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      ir;
    logic             ir_load;
    logic             core_rst_f;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    sisc_run_ctrl #(
        .RST_CYCLES (2),
        .TIMEOUT    (20),
        .HALT_OP    (4'hF),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ir          (ir),
        .ir_load     (ir_load),
        .core_rst_f  (core_rst_f),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic crf, input logic run,
                                input logic dn, input logic to,
                                input int cyc, input int ins);
        check({tag, ".core_rst_f"}, {31'd0, core_rst_f}, {31'd0, crf});
        check({tag, ".running"},    {31'd0, running},    {31'd0, run});
        check({tag, ".done"},       {31'd0, done},       {31'd0, dn});
        check({tag, ".timeout"},    {31'd0, timeout},    {31'd0, to});
        check({tag, ".cycle"},      {16'd0, cycle_count}, cyc);
        check({tag, ".instr"},      {16'd0, instr_count}, ins);
    endtask

    // From DONE/TOUT: one start edge, then two HOLD edges into RUN.
    task automatic restart(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check_status({tag, ".start_edge"}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step();
        check({tag, ".hold1.core_rst_f"}, {31'd0, core_rst_f}, 32'd0);
        step();
        check_status({tag, ".run_entry"}, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        ir      = 32'd0;
        ir_load = 1'b0;

        // Power-up
        #12;
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        #8;
        rst = 1'b0;
        step();
        check("pwr.edge1.core_rst_f", {31'd0, core_rst_f}, 32'd0);
        step();
        check_status("pwr.edge2", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

        // Normal run: fetches on even RUN edges, halt on edge 12
        for (int k = 1; k <= 12; k++) begin
            ir_load = (k % 2 == 0);
            ir      = (k == 12) ? 32'hF000_0000 : 32'h0123_4567;
            step();
            if (k == 11) check_status("run.edge11", 1'b1, 1'b1, 1'b0, 1'b0, 11, 5);
        end
        ir_load = 1'b0;
        ir      = 32'd0;
        check_status("halt", 1'b0, 1'b0, 1'b1, 1'b0, 12, 6);
        step();
        check_status("done.hold", 1'b0, 1'b0, 1'b1, 1'b0, 12, 6);

        // Restart from DONE, then start during RUN ignored, then watchdog
        restart("rs1");
        for (int k = 1; k <= 20; k++) begin
            start = (k <= 3);
            step();
            if (k == 3)  check_status("run.start_ignored", 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
            if (k == 19) check_status("run.edge19", 1'b1, 1'b1, 1'b0, 1'b0, 19, 0);
        end
        start = 1'b0;
        check_status("watchdog", 1'b0, 1'b0, 1'b0, 1'b1, 20, 0);

        // Restart from TOUT, halt on the watchdog edge: halt wins
        restart("rs2");
        for (int k = 1; k <= 20; k++) begin
            ir_load = (k == 20);
            ir      = (k == 20) ? 32'hF000_0000 : 32'd0;
            step();
        end
        ir_load = 1'b0;
        ir      = 32'd0;
        check_status("tie", 1'b0, 1'b0, 1'b1, 1'b0, 20, 1);

        // Asynchronous reset mid-run at RUN cycle 7
        restart("rs3");
        for (int k = 1; k <= 7; k++) begin
            ir_load = (k == 3);
            step();
        end
        ir_load = 1'b0;
        check_status("run.edge7", 1'b1, 1'b1, 1'b0, 1'b0, 7, 1);
        #3;
        rst = 1'b1;
        #1;
        check_status("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        #2;
        rst = 1'b0;
        // Halt fetches during HOLD must be ignored
        ir_load = 1'b1;
        ir      = 32'hF000_0000;
        step();
        check("rehold.edge1.core_rst_f", {31'd0, core_rst_f}, 32'd0);
        step();
        ir_load = 1'b0;
        ir      = 32'd0;
        check_status("rehold.edge2", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        step();
        check_status("rehold.run1", 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
